fetch_thread_scheduler: RTL and testbench
=========================================

Name: fetch_thread_scheduler

Overview:
- Parametrised multithreaded fetch front-end. It succeeds the fixed round-robin IF stage.
- Holds one PC and one state per hardware thread, and picks a ready thread each cycle with a round-robin that skips blocked threads.
- Issues one fetch per cycle to the I-TLB/I-cache pair. Parks a thread on a cache miss until its refill completes, then replays the same PC.
- Squashes on redirect, and delivers instructions to ID through a valid/ready handshake with a 1-entry skid buffer.

Parameters:
- N_THREADS, 4, number of hardware threads (≥2); TID_W = $clog2(N_THREADS)
- VADDR_W, 32, virtual PC width
- INSTR_W, 32, instruction width
- PC_STEP, 4, PC increment on a delivered hit
- RESET_PC, 32'h0000_1000, PC of every thread after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- thread_en  in  N_THREADS  thread enabled; a disabled thread is never selected
- stall  in  N_THREADS  external per-thread stall from later stages; level-sensitive
- req_valid  out  1  fetch request this cycle
- req_pc  out  VADDR_W  request PC
- req_thread  out  TID_W  request thread
- resp_valid  in  1  response; asserted exactly 1 cycle after req_valid
- resp_itlb_miss  in  1  translation miss
- resp_icache_miss  in  1  cache miss; refill started by the cache
- resp_instr  in  INSTR_W  instruction, valid on a hit
- fill_done  in  1  refill complete pulse
- fill_thread  in  TID_W  thread the refill belongs to
- redirect_en  in  1  redirect pulse (branch or exception)
- redirect_thread  in  TID_W  thread being redirected
- redirect_pc  in  VADDR_W  new PC
- id_valid  out  1  output holds an instruction or exception token
- id_ready  in  1  ID accepts
- id_pc  out  VADDR_W  PC of delivered item
- id_instr  out  INSTR_W  instruction (0 when id_itlb_miss)
- id_thread  out  TID_W  thread of delivered item
- id_itlb_miss  out  1  item is an I-TLB miss token

Behaviour:
- Reset (async, rst_n low):
  - All PCs = RESET_PC; all thread states = READY; round-robin pointer = N_THREADS-1.
  - No request in flight; skid buffer and output register empty.
  - req_valid=0, id_valid=0, all other outputs 0.
  - Reset mid-refill drops all state; any later fill_done is ignored.
- Per-thread state:
  - READY: selectable.
  - INFLIGHT: request issued, response pending.
  - WAIT_FILL: waiting for the cache refill.
  - WAIT_REDIR: I-TLB miss delivered; waits for a redirect.
- Selection (cycle t): eligible = READY & thread_en & ~stall.
  - Grant the first eligible thread after the pointer, with wrap-around.
  - The pointer is updated to the granted thread.
  - Issue is allowed only if the skid buffer is empty.
  - On issue: req_valid=1, the thread goes to INFLIGHT, req_pc = that thread's PC.
  - With no eligible thread or a full skid buffer: req_valid=0 and the pointer is unchanged.
- Response (cycle t+1) for the INFLIGHT thread:
  - Hit: enqueue {pc, instr, thread, 0}; PC += PC_STEP (modulo 2^VADDR_W); thread -> READY.
  - resp_icache_miss: nothing enqueued; PC unchanged; thread -> WAIT_FILL.
  - resp_itlb_miss (takes priority over the cache miss): enqueue {pc, 0, thread, 1}; thread -> WAIT_REDIR.
- fill_done:
  - If fill_thread is in WAIT_FILL, it goes to READY and the same PC is refetched.
  - Otherwise fill_done is ignored.
- Redirect:
  - The target thread's PC = redirect_pc and its state -> READY, from any state.
  - A response arriving the same cycle for that thread is squashed: nothing enqueued, no PC update.
  - A redirect in the same cycle as that thread's selection suppresses the issue; the thread stays READY.
  - A later fill_done for that thread is ignored.
- Output path:
  - The output register loads when empty or when id_ready=1.
  - Otherwise the item goes to the skid buffer.
  - The skid buffer drains into the output register first.
  - Order is preserved; no item is dropped or duplicated.
- Latency: select at t, response at t+1, id_valid at t+2 when the path is unblocked.
  - Sustained throughput is 1 item/cycle with id_ready held high.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_fetched (32 bits): count of hit items accepted by ID.
  - perf_misses (32 bits): count of responses with resp_icache_miss.
  - Both are saturating at 2^32-1 and are cleared by reset.
- When undefined, these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset, all 4 threads enabled, id_ready=1, all hits -> grants T0,T1,T2,T3,T0; id_pc sequence 0x1000×4 then 0x1004; first id_valid 2 cycles after the first req_valid.
- stall=4'b0010 -> T1 never requested; order T0,T2,T3,T0; releasing the stall puts T1 back in rotation at the next pass of the pointer.
- T2 gets resp_icache_miss at PC 0x1000 -> T2 skipped; fill_done with fill_thread=2 five cycles later -> T2 refetches 0x1000 and delivers it once.
- T1 resp_itlb_miss at 0x1004 -> id_itlb_miss=1, id_instr=0; T1 idle until redirect_pc=0x2000 -> next T1 request at 0x2000.
- id_ready=0 for 6 cycles while fetching -> at most 2 items buffered, req_valid drops; on release, items delivered in issue order with none lost.
- redirect for T0 in the same cycle as T0's hit response -> response squashed; next T0 request uses the redirect PC; an unrelated fill_done for T0 is ignored.

Source files
------------

// File: rtl/fetch_thread_scheduler.sv
// Multithreaded fetch front-end: round-robin thread pick, miss parking, redirect squash, skid-buffered ID handoff.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_misses counters.
module fetch_thread_scheduler #(
  parameter int unsigned N_THREADS = 4,
  parameter int unsigned VADDR_W   = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [VADDR_W-1:0] RESET_PC = 'h1000,
  localparam int unsigned TID_W = $clog2(N_THREADS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_THREADS-1:0] thread_en,
  input  logic [N_THREADS-1:0] stall,
  output logic                 req_valid,
  output logic [VADDR_W-1:0]   req_pc,
  output logic [TID_W-1:0]     req_thread,
  input  logic                 resp_valid,
  input  logic                 resp_itlb_miss,
  input  logic                 resp_icache_miss,
  input  logic [INSTR_W-1:0]   resp_instr,
  input  logic                 fill_done,
  input  logic [TID_W-1:0]     fill_thread,
  input  logic                 redirect_en,
  input  logic [TID_W-1:0]     redirect_thread,
  input  logic [VADDR_W-1:0]   redirect_pc,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [VADDR_W-1:0]   id_pc,
  output logic [INSTR_W-1:0]   id_instr,
  output logic [TID_W-1:0]     id_thread,
  output logic                 id_itlb_miss
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_misses
`endif
);

  typedef enum logic [1:0] {
    ST_READY,
    ST_INFLIGHT,
    ST_WAIT_FILL,
    ST_WAIT_REDIR
  } thr_state_t;

  thr_state_t         r_state [N_THREADS];
  logic [VADDR_W-1:0] r_pc    [N_THREADS];
  logic [TID_W-1:0]   r_ptr;
  logic               r_active;
  logic               r_inf_valid;
  logic [TID_W-1:0]   r_inf_tid;

  logic               r_out_valid, r_out_itlb, r_sk_valid, r_sk_itlb;
  logic [VADDR_W-1:0] r_out_pc, r_sk_pc;
  logic [INSTR_W-1:0] r_out_instr, r_sk_instr;
  logic [TID_W-1:0]   r_out_tid, r_sk_tid;

  logic [N_THREADS-1:0] w_elig;
  logic                 w_grant_found, w_issue, w_squash, w_resp, w_enq, w_issue_ok;
  logic [TID_W-1:0]     w_grant;
  logic [INSTR_W-1:0]   w_enq_instr;

  assign w_squash    = r_inf_valid && resp_valid && redirect_en && (redirect_thread == r_inf_tid);
  assign w_resp      = r_inf_valid && resp_valid && !w_squash;
  assign w_enq       = w_resp && (resp_itlb_miss || !resp_icache_miss);
  assign w_enq_instr = resp_itlb_miss ? '0 : resp_instr;
  // Issue only if the response it produces next cycle is guaranteed a slot.
  assign w_issue_ok  = r_active && !r_sk_valid && !(w_enq && r_out_valid && !id_ready);
  assign w_issue     = w_issue_ok && w_grant_found;

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < N_THREADS; i++)
      w_elig[i] = (r_state[i] == ST_READY) && thread_en[i] && !stall[i]
                  && !(redirect_en && (redirect_thread == TID_W'(i)));
  end

  always_comb begin
    logic [TID_W-1:0] idx;
    idx           = '0;
    w_grant_found = 1'b0;
    w_grant       = '0;
    for (int unsigned k = 1; k <= N_THREADS; k++) begin
      idx = TID_W'((32'(r_ptr) + k) % N_THREADS);
      if (!w_grant_found && w_elig[idx]) begin
        w_grant_found = 1'b1;
        w_grant       = idx;
      end
    end
  end

  assign req_valid  = w_issue;
  assign req_pc     = w_issue ? r_pc[w_grant] : '0;
  assign req_thread = w_issue ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        r_state[i] <= ST_READY;
        r_pc[i]    <= RESET_PC;
      end
      r_ptr       <= TID_W'(N_THREADS - 1);
      r_active    <= 1'b0;
      r_inf_valid <= 1'b0;
      r_inf_tid   <= '0;
    end else begin
      r_active    <= 1'b1;
      r_inf_valid <= w_issue;
      r_inf_tid   <= w_grant;
      if (w_issue) begin
        r_ptr            <= w_grant;
        r_state[w_grant] <= ST_INFLIGHT;
      end
      if (w_resp) begin
        if (resp_itlb_miss)
          r_state[r_inf_tid] <= ST_WAIT_REDIR;
        else if (resp_icache_miss)
          r_state[r_inf_tid] <= ST_WAIT_FILL;
        else begin
          r_state[r_inf_tid] <= ST_READY;
          r_pc[r_inf_tid]    <= r_pc[r_inf_tid] + VADDR_W'(PC_STEP);
        end
      end
      if (fill_done && (32'(fill_thread) < N_THREADS) && (r_state[fill_thread] == ST_WAIT_FILL))
        r_state[fill_thread] <= ST_READY;
      // Redirect is applied last so it overrides any same-cycle update of that thread.
      if (redirect_en && (32'(redirect_thread) < N_THREADS)) begin
        r_pc[redirect_thread]    <= redirect_pc;
        r_state[redirect_thread] <= ST_READY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_tid   <= '0;
      r_out_itlb  <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_pc     <= '0;
      r_sk_instr  <= '0;
      r_sk_tid    <= '0;
      r_sk_itlb   <= 1'b0;
    end else if (!r_out_valid || id_ready) begin
      if (r_sk_valid) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= r_sk_pc;
        r_out_instr <= r_sk_instr;
        r_out_tid   <= r_sk_tid;
        r_out_itlb  <= r_sk_itlb;
        r_sk_valid  <= w_enq;
        if (w_enq) begin
          r_sk_pc    <= r_pc[r_inf_tid];
          r_sk_instr <= w_enq_instr;
          r_sk_tid   <= r_inf_tid;
          r_sk_itlb  <= resp_itlb_miss;
        end
      end else begin
        r_out_valid <= w_enq;
        if (w_enq) begin
          r_out_pc    <= r_pc[r_inf_tid];
          r_out_instr <= w_enq_instr;
          r_out_tid   <= r_inf_tid;
          r_out_itlb  <= resp_itlb_miss;
        end
      end
    end else if (w_enq) begin
      r_sk_valid <= 1'b1;
      r_sk_pc    <= r_pc[r_inf_tid];
      r_sk_instr <= w_enq_instr;
      r_sk_tid   <= r_inf_tid;
      r_sk_itlb  <= resp_itlb_miss;
    end
  end

  assign id_valid     = r_out_valid;
  assign id_pc        = r_out_pc;
  assign id_instr     = r_out_instr;
  assign id_thread    = r_out_tid;
  assign id_itlb_miss = r_out_itlb;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_misses  <= '0;
    end else begin
      if (r_out_valid && id_ready && !r_out_itlb && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (resp_valid && resp_icache_miss && (perf_misses != '1))
        perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_thread_scheduler.sv
// Randomized bench for fetch_thread_scheduler against a queue-based thread/occupancy model.
module tb_fetch_thread_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  thread_en, stall;
  logic        req_valid;
  logic [31:0] req_pc;
  logic [1:0]  req_thread;
  logic        resp_valid, resp_itlb_miss, resp_icache_miss;
  logic [31:0] resp_instr;
  logic        fill_done;
  logic [1:0]  fill_thread;
  logic        redirect_en;
  logic [1:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr;
  logic [1:0]  id_thread;
  logic        id_itlb_miss;

  fetch_thread_scheduler #(.N_THREADS(4), .VADDR_W(32), .INSTR_W(32), .PC_STEP(4),
                           .RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en), .stall(stall),
    .req_valid(req_valid), .req_pc(req_pc), .req_thread(req_thread),
    .resp_valid(resp_valid), .resp_itlb_miss(resp_itlb_miss),
    .resp_icache_miss(resp_icache_miss), .resp_instr(resp_instr),
    .fill_done(fill_done), .fill_thread(fill_thread),
    .redirect_en(redirect_en), .redirect_thread(redirect_thread), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_thread(id_thread), .id_itlb_miss(id_itlb_miss));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  tid;
    logic        itlb;
  } item_t;

  // Model: 0 ready, 1 inflight, 2 wait fill, 3 wait redirect
  item_t       mq[$];
  int          mst[N];
  logic [31:0] mpc[N];
  int          wcnt[N];
  int          mptr, mptid;
  bit          mpend, mactive;

  bit          e_rv, e_iv;
  logic [31:0] e_rpc;
  logic [1:0]  e_rtid;
  item_t       e_it;

  int checks = 0, failures = 0, cyc = 0;

  logic [3:0]  k_en, k_stall;
  bit          k_rand_stall, k_rand_rpc;
  int          k_ready_mode, k_icm_pct, k_itlb_pct, k_redir_pct, k_spur_pct;
  int          k_fill_delay, k_redir_delay;
  logic [31:0] k_redir_pc, k_force_itlb_pc, k_squash_pc;
  int          k_force_icm_tid, k_force_itlb_tid, k_squash_tid, k_spur_fill_tid;

  task automatic knobs_default();
    k_en = 4'hF; k_stall = 4'h0; k_rand_stall = 0; k_rand_rpc = 0;
    k_ready_mode = 0; k_icm_pct = 0; k_itlb_pct = 0; k_redir_pct = 0; k_spur_pct = 0;
    k_fill_delay = 5; k_redir_delay = 3; k_redir_pc = 32'h2000;
    k_force_icm_tid = -1; k_force_itlb_tid = -1; k_force_itlb_pc = '0;
    k_squash_tid = -1; k_squash_pc = '0; k_spur_fill_tid = -1;
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) begin
      mst[i] = 0; mpc[i] = 32'h1000; wcnt[i] = 0;
    end
    mptr = N - 1; mptid = 0; mpend = 0; mactive = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    thread_en = 4'hF; stall = '0; resp_valid = 0; resp_itlb_miss = 0; resp_icache_miss = 0;
    resp_instr = '0; fill_done = 0; fill_thread = '0; redirect_en = 0; redirect_thread = '0;
    redirect_pc = '0; id_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Drives one cycle of stimulus at the negedge and advances the model.
  task automatic step();
    int r, g, idx;
    bit sq, enq, acc;
    item_t ni;
    logic [31:0] rnd;
    @(negedge clk);
    cyc++;
    thread_en = k_en;
    stall = k_rand_stall ? 4'($urandom) : k_stall;
    id_ready = (k_ready_mode == 1) ? 1'($urandom_range(0, 1)) : (k_ready_mode == 0);
    resp_valid = mpend; resp_itlb_miss = 0; resp_icache_miss = 0; resp_instr = '0;
    fill_done = 0; fill_thread = '0; redirect_en = 0; redirect_thread = '0; redirect_pc = '0;
    if (mpend) begin
      resp_instr = $urandom;
      r = $urandom_range(0, 99);
      if (mptid == k_force_icm_tid) begin
        resp_icache_miss = 1; k_force_icm_tid = -1;
      end else if (mptid == k_force_itlb_tid && mpc[mptid] == k_force_itlb_pc) begin
        resp_itlb_miss = 1; k_force_itlb_tid = -1;
      end else if (r < k_itlb_pct) begin
        resp_itlb_miss = 1; resp_icache_miss = 1'($urandom_range(0, 1));
      end else if (r < k_itlb_pct + k_icm_pct) begin
        resp_icache_miss = 1;
      end
      if (mptid == k_squash_tid && !resp_itlb_miss && !resp_icache_miss) begin
        redirect_en = 1; redirect_thread = 2'(mptid); redirect_pc = k_squash_pc; k_squash_tid = -1;
      end
    end
    for (int i = 0; i < N; i++)
      if (mst[i] == 2 && wcnt[i] >= k_fill_delay) begin
        fill_done = 1; fill_thread = 2'(i);
      end
    if (!fill_done && k_spur_fill_tid >= 0) begin
      fill_done = 1; fill_thread = 2'(k_spur_fill_tid); k_spur_fill_tid = -1;
    end else if (!fill_done && $urandom_range(0, 99) < k_spur_pct) begin
      fill_done = 1; fill_thread = 2'($urandom_range(0, 3));
    end
    if (!redirect_en)
      for (int i = 0; i < N; i++)
        if (!redirect_en && mst[i] == 3 && wcnt[i] >= k_redir_delay) begin
          rnd = $urandom;
          redirect_en = 1; redirect_thread = 2'(i);
          redirect_pc = k_rand_rpc ? (rnd & 32'hFFFF_FFFC) : k_redir_pc;
        end
    if (!redirect_en && $urandom_range(0, 99) < k_redir_pct) begin
      rnd = $urandom;
      redirect_en = 1; redirect_thread = 2'($urandom_range(0, 3)); redirect_pc = rnd & 32'hFFFF_FFFC;
    end
    #1;
    e_iv = mq.size() > 0;
    if (e_iv) e_it = mq[0];
    acc = id_ready && e_iv;
    sq  = mpend && redirect_en && (int'(redirect_thread) == mptid);
    enq = mpend && !sq && (resp_itlb_miss || !resp_icache_miss);
    if (enq) begin
      ni.pc = mpc[mptid]; ni.instr = resp_itlb_miss ? 32'h0 : resp_instr;
      ni.tid = 2'(mptid); ni.itlb = resp_itlb_miss;
    end
    g = -1;
    if (mactive && mq.size() <= 1 && (mq.size() + int'(enq) - int'(acc)) <= 1)
      for (int k = 1; k <= N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && mst[idx] == 0 && thread_en[idx] && !stall[idx]
            && !(redirect_en && int'(redirect_thread) == idx))
          g = idx;
      end
    e_rv = g >= 0;
    e_rpc = e_rv ? mpc[g] : 32'h0;
    e_rtid = e_rv ? 2'(g) : 2'd0;
    if (fill_done && mst[fill_thread] == 2) mst[fill_thread] = 0;
    if (mpend && !sq) begin
      if (resp_itlb_miss) mst[mptid] = 3;
      else if (resp_icache_miss) mst[mptid] = 2;
      else begin mst[mptid] = 0; mpc[mptid] = mpc[mptid] + 32'd4; end
    end
    if (acc) void'(mq.pop_front());
    if (enq) mq.push_back(ni);
    if (e_rv) begin mst[g] = 1; mptr = g; end
    mpend = e_rv; mptid = g;
    if (redirect_en) begin mpc[redirect_thread] = redirect_pc; mst[redirect_thread] = 0; end
    for (int i = 0; i < N; i++) wcnt[i] = (mst[i] >= 2) ? wcnt[i] + 1 : 0;
    mactive = 1;
  endtask

  task automatic test_reset();
    knobs_default();
    apply_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_valid !== 0 || req_pc !== 0 || req_thread !== 0 || id_valid !== 0 || id_pc !== 0
        || id_instr !== 0 || id_thread !== 0 || id_itlb_miss !== 0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b/%h/%0d id=%b/%h/%h/%0d/%b required all 0",
               req_valid, req_pc, req_thread, id_valid, id_pc, id_instr, id_thread, id_itlb_miss);
    end
    apply_reset();
  endtask

  task automatic test_round_robin();
    int nrq = 0, first_rq = -1, first_id = -1;
    int exp_t[5];
    logic [31:0] exp_pc[5];
    int got_t[5];
    logic [31:0] got_pc[5];
    exp_t = '{0, 1, 2, 3, 0};
    exp_pc = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
    knobs_default();
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if (req_valid !== e_rv || req_pc !== e_rpc || req_thread !== e_rtid) begin
        failures++;
        $display("FAIL rr_req cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, req_valid, req_pc, req_thread, e_rv, e_rpc, e_rtid);
      end
      checks++;
      if (id_valid !== e_iv || (e_iv && (id_pc !== e_it.pc || id_instr !== e_it.instr
          || id_thread !== e_it.tid || id_itlb_miss !== e_it.itlb))) begin
        failures++;
        $display("FAIL rr_id cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, id_valid, id_pc, id_thread, e_iv, e_it.pc, e_it.tid);
      end
      if (req_valid === 1'b1 && nrq < 5) begin
        got_t[nrq] = int'(req_thread); got_pc[nrq] = req_pc; nrq++;
        if (first_rq < 0) first_rq = i;
      end
      if (id_valid === 1'b1 && first_id < 0) first_id = i;
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (j >= nrq || got_t[j] != exp_t[j] || got_pc[j] !== exp_pc[j]) begin
        failures++;
        $display("FAIL rr_order idx=%0d got t=%0d pc=%h required t=%0d pc=%h (seen %0d)",
                 j, got_t[j], got_pc[j], exp_t[j], exp_pc[j], nrq);
      end
    end
    checks++;
    if (first_rq < 0 || first_id - first_rq != 2) begin
      failures++;
      $display("FAIL rr_latency got %0d required 2", first_id - first_rq);
    end
  endtask

  task automatic test_stall();
    int t1_stalled = 0, t1_after = 0;
    knobs_default();
    k_stall = 4'b0010;
    for (int i = 0; i < 26; i++) begin
      if (i == 16) k_stall = 4'b0000;
      step();
      checks++;
      if (req_valid !== e_rv || req_pc !== e_rpc || req_thread !== e_rtid) begin
        failures++;
        $display("FAIL stall_req cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, req_valid, req_pc, req_thread, e_rv, e_rpc, e_rtid);
      end
      checks++;
      if (id_valid !== e_iv || (e_iv && (id_pc !== e_it.pc || id_instr !== e_it.instr
          || id_thread !== e_it.tid || id_itlb_miss !== e_it.itlb))) begin
        failures++;
        $display("FAIL stall_id cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, id_valid, id_pc, id_thread, e_iv, e_it.pc, e_it.tid);
      end
      if (i >= 1 && i < 16 && req_valid === 1'b1 && req_thread === 2'd1) t1_stalled++;
      if (i >= 16 && req_valid === 1'b1 && req_thread === 2'd1) t1_after++;
    end
    checks++;
    if (t1_stalled != 0 || t1_after == 0) begin
      failures++;
      $display("FAIL stall_t1 got stalled_reqs=%0d after_reqs=%0d required 0 and >0",
               t1_stalled, t1_after);
    end
  endtask

  task automatic test_miss_and_redirect();
    int t2_deliv = 0;
    bit tok_seen = 0, t1_checked = 0;
    knobs_default();
    apply_reset();
    k_force_icm_tid = 2;
    k_force_itlb_tid = 1; k_force_itlb_pc = 32'h1004;
    for (int i = 0; i < 36; i++) begin
      step();
      checks++;
      if (req_valid !== e_rv || req_pc !== e_rpc || req_thread !== e_rtid) begin
        failures++;
        $display("FAIL miss_req cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, req_valid, req_pc, req_thread, e_rv, e_rpc, e_rtid);
      end
      checks++;
      if (id_valid !== e_iv || (e_iv && (id_pc !== e_it.pc || id_instr !== e_it.instr
          || id_thread !== e_it.tid || id_itlb_miss !== e_it.itlb))) begin
        failures++;
        $display("FAIL miss_id cyc=%0d got v=%b pc=%h i=%h t=%0d x=%b required v=%b pc=%h i=%h t=%0d x=%b",
                 cyc, id_valid, id_pc, id_instr, id_thread, id_itlb_miss,
                 e_iv, e_it.pc, e_it.instr, e_it.tid, e_it.itlb);
      end
      if (tok_seen && !t1_checked && req_valid === 1'b1 && req_thread === 2'd1) begin
        t1_checked = 1;
        checks++;
        if (req_pc !== 32'h2000) begin
          failures++;
          $display("FAIL redirect_pc got %h required 00002000", req_pc);
        end
      end
      if (id_valid === 1'b1 && id_thread === 2'd2 && id_pc === 32'h1000 && id_itlb_miss === 1'b0)
        t2_deliv++;
      if (id_valid === 1'b1 && id_thread === 2'd1 && id_itlb_miss === 1'b1
          && id_pc === 32'h1004 && id_instr === 32'h0)
        tok_seen = 1;
    end
    checks++;
    if (t2_deliv != 1 || !tok_seen || !t1_checked) begin
      failures++;
      $display("FAIL miss_summary got t2_deliv=%0d tok=%0d t1_req=%0d required 1 1 1",
               t2_deliv, tok_seen, t1_checked);
    end
  endtask

  task automatic test_back_to_back();
    int blocked_reqs = 0;
    knobs_default();
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      k_ready_mode = (i < 6) ? 2 : 0;
      step();
      checks++;
      if (req_valid !== e_rv || req_pc !== e_rpc || req_thread !== e_rtid) begin
        failures++;
        $display("FAIL b2b_req cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, req_valid, req_pc, req_thread, e_rv, e_rpc, e_rtid);
      end
      checks++;
      if (id_valid !== e_iv || (e_iv && (id_pc !== e_it.pc || id_instr !== e_it.instr
          || id_thread !== e_it.tid || id_itlb_miss !== e_it.itlb))) begin
        failures++;
        $display("FAIL b2b_id cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, id_valid, id_pc, id_thread, e_iv, e_it.pc, e_it.tid);
      end
      if (i >= 3 && i < 6 && req_valid !== 1'b0) blocked_reqs++;
    end
    checks++;
    if (blocked_reqs != 0) begin
      failures++;
      $display("FAIL b2b_block got %0d requests while full required 0", blocked_reqs);
    end
  endtask

  task automatic test_redirect_squash();
    int t0_old = 0;
    bit squashed = 0, t0_checked = 0;
    knobs_default();
    apply_reset();
    k_squash_tid = 0; k_squash_pc = 32'h3000;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) k_spur_fill_tid = 0;
      step();
      checks++;
      if (req_valid !== e_rv || req_pc !== e_rpc || req_thread !== e_rtid) begin
        failures++;
        $display("FAIL sq_req cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, req_valid, req_pc, req_thread, e_rv, e_rpc, e_rtid);
      end
      checks++;
      if (id_valid !== e_iv || (e_iv && (id_pc !== e_it.pc || id_instr !== e_it.instr
          || id_thread !== e_it.tid || id_itlb_miss !== e_it.itlb))) begin
        failures++;
        $display("FAIL sq_id cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, id_valid, id_pc, id_thread, e_iv, e_it.pc, e_it.tid);
      end
      if (squashed && !t0_checked && req_valid === 1'b1 && req_thread === 2'd0) begin
        t0_checked = 1;
        checks++;
        if (req_pc !== 32'h3000) begin
          failures++;
          $display("FAIL squash_pc got %h required 00003000", req_pc);
        end
      end
      if (redirect_en && resp_valid && redirect_thread == 2'd0) squashed = 1;
      if (id_valid === 1'b1 && id_thread === 2'd0 && id_pc === 32'h1000) t0_old++;
    end
    checks++;
    if (!squashed || !t0_checked || t0_old != 0) begin
      failures++;
      $display("FAIL squash_summary got sq=%0d t0_req=%0d old_deliv=%0d required 1 1 0",
               squashed, t0_checked, t0_old);
    end
  endtask

  task automatic test_random();
    knobs_default();
    apply_reset();
    k_rand_stall = 1; k_ready_mode = 1; k_icm_pct = 15; k_itlb_pct = 6;
    k_redir_pct = 3; k_spur_pct = 5; k_fill_delay = 3; k_redir_delay = 4; k_rand_rpc = 1;
    for (int i = 0; i < 640; i++) begin
      if (i % 60 == 0 && i < 600) k_en = 4'($urandom_range(1, 15));
      if (i == 600) begin
        k_en = 4'hF; k_rand_stall = 0; k_icm_pct = 100; k_itlb_pct = 0; k_redir_pct = 0;
        k_spur_pct = 0; k_fill_delay = 1000; k_ready_mode = 0;
      end
      if (i == 612) begin
        apply_reset();
        k_icm_pct = 0; k_fill_delay = 3; k_spur_fill_tid = 1;
      end
      step();
      checks++;
      if (req_valid !== e_rv || req_pc !== e_rpc || req_thread !== e_rtid) begin
        failures++;
        $display("FAIL rand_req cyc=%0d got v=%b pc=%h t=%0d required v=%b pc=%h t=%0d",
                 cyc, req_valid, req_pc, req_thread, e_rv, e_rpc, e_rtid);
      end
      checks++;
      if (id_valid !== e_iv || (e_iv && (id_pc !== e_it.pc || id_instr !== e_it.instr
          || id_thread !== e_it.tid || id_itlb_miss !== e_it.itlb))) begin
        failures++;
        $display("FAIL rand_id cyc=%0d got v=%b pc=%h i=%h t=%0d x=%b required v=%b pc=%h i=%h t=%0d x=%b",
                 cyc, id_valid, id_pc, id_instr, id_thread, id_itlb_miss,
                 e_iv, e_it.pc, e_it.instr, e_it.tid, e_it.itlb);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_stall();
    test_miss_and_redirect();
    test_back_to_back();
    test_redirect_squash();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
